// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding memory request, registered IF/ID
// output with a one-entry skid buffer, and branch redirect with stale-ack drop.
module instruction_fetch (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        Valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] redirect_pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic        skid_valid;
    logic [31:0] pc_next;
    logic        consume;

    assign IMemAddr = fetch_pc;
    assign pc_next  = fetch_pc + 32'd4;
    assign consume  = Valid && !Stall;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= S_IDLE;
            IMemReq     <= 1'b0;
            fetch_pc    <= '0;
            redirect_pc <= '0;
            skid_instr  <= '0;
            skid_pc4    <= '0;
            skid_valid  <= 1'b0;
            Instruction <= '0;
            PCPlus4     <= '0;
            Valid       <= 1'b0;
        end else begin
            // Default: a consumed word leaves the output unless reloaded below.
            if (consume)
                Valid <= 1'b0;

            if (BranchTaken) begin
                Valid      <= 1'b0;
                skid_valid <= 1'b0;
                unique case (state)
                    S_REQ: begin
                        if (IMemAck) begin
                            fetch_pc <= BranchTarget;
                        end else begin
                            // Request still in flight: its ack must be swallowed.
                            redirect_pc <= BranchTarget;
                            state       <= S_DROP;
                        end
                    end
                    S_DROP: redirect_pc <= BranchTarget;
                    default: begin
                        fetch_pc <= BranchTarget;
                        state    <= S_REQ;
                        IMemReq  <= 1'b1;
                    end
                endcase
            end else begin
                unique case (state)
                    S_IDLE: begin
                        state   <= S_REQ;
                        IMemReq <= 1'b1;
                    end
                    S_REQ: begin
                        if (IMemAck) begin
                            fetch_pc <= pc_next;
                            if (!Valid || !Stall) begin
                                Instruction <= IMemData;
                                PCPlus4     <= pc_next;
                                Valid       <= 1'b1;
                            end else begin
                                skid_instr <= IMemData;
                                skid_pc4   <= pc_next;
                                skid_valid <= 1'b1;
                                state      <= S_HOLD;
                                IMemReq    <= 1'b0;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (consume && skid_valid) begin
                            Instruction <= skid_instr;
                            PCPlus4     <= skid_pc4;
                            Valid       <= 1'b1;
                            skid_valid  <= 1'b0;
                            state       <= S_REQ;
                            IMemReq     <= 1'b1;
                        end
                    end
                    S_DROP: begin
                        if (IMemAck) begin
                            fetch_pc <= redirect_pc;
                            state    <= S_REQ;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios push expected
// IF/ID words; a negedge monitor pops and compares each newly presented word.
module tb_instruction_fetch;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic        Valid;

    instruction_fetch dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .IMemData     (IMemData),
        .Instruction  (Instruction),
        .PCPlus4      (PCPlus4),
        .Valid        (Valid)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
        exp_t e;
        e.instr = instr;
        e.pc4   = pc4;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // Memory model: serves one request at a time, data = addr | 0xA000.
    int          credits = 0;
    int          mem_lat = 1;
    int          cnt     = 0;
    bit          pending = 0;
    logic        mem_ack = 1'b0;
    logic [31:0] req_addr = '0;

    assign IMemAck = mem_ack & ~Rst;

    initial begin
        IMemData = '0;
        forever begin
            @(posedge Clk);
            #1;
            if (Rst) begin
                mem_ack = 1'b0;
                pending = 0;
            end else begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    pending = 0;
                end
                if (!pending && IMemReq && credits > 0) begin
                    pending  = 1;
                    credits--;
                    cnt      = mem_lat;
                    req_addr = IMemAddr;
                end
                if (pending) begin
                    if (cnt == 0) begin
                        mem_ack  = 1'b1;
                        IMemData = req_addr | 32'h0000_A000;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Monitor: a word is new when Valid rises or the previous one was consumed.
    logic prev_valid = 1'b0;
    logic prev_stall = 1'b0;

    always @(negedge Clk) begin
        exp_t e;
        if (!Rst && Valid && (!prev_valid || !prev_stall)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got instr 0x%08h pc4 0x%08h, expected none", Instruction, PCPlus4);
            end else begin
                e = sb.pop_front();
                check("sb_instr", Instruction, e.instr);
                check("sb_pc4", PCPlus4, e.pc4);
            end
        end
        prev_valid = Valid;
        prev_stall = Stall;
    end

    task automatic wait_drain(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check(name, sb.size(), 32'd0);
    endtask

    task automatic wait_addr(input string name, input logic [31:0] a, input int max);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (IMemReq && IMemAddr == a) begin
                hit = 1'b1;
                break;
            end
        end
        check(name, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        logic hit;
        Rst = 1'b1;
        Stall = 1'b0;
        BranchTaken = 1'b0;
        BranchTarget = '0;

        // Reset state
        tick();
        tick();
        check("rst_req", {31'd0, IMemReq}, 32'd0);
        check("rst_addr", IMemAddr, 32'd0);
        check("rst_instr", Instruction, 32'd0);
        check("rst_pc4", PCPlus4, 32'd0);
        check("rst_valid", {31'd0, Valid}, 32'd0);

        // Scenario 1: three sequential fetches
        Rst = 1'b0;
        credits = 3;
        mem_lat = 1;
        push(32'h0000_A000, 32'h4);
        push(32'h0000_A004, 32'h8);
        push(32'h0000_A008, 32'hC);
        #1 check("idle_req", {31'd0, IMemReq}, 32'd0);
        tick();
        check("first_req", {31'd0, IMemReq}, 32'd1);
        check("first_addr", IMemAddr, 32'd0);
        wait_drain("s1_drain", 30);

        // Scenario 2: stall with skid buffer
        Stall = 1'b1;
        credits = 2;
        push(32'h0000_A00C, 32'h10);
        push(32'h0000_A010, 32'h14);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!IMemReq) begin
                hit = 1'b1;
                break;
            end
        end
        check("s2_hold_reached", {31'd0, hit}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("s2_hold_req", {31'd0, IMemReq}, 32'd0);
            check("s2_hold_instr", Instruction, 32'h0000_A00C);
            check("s2_hold_valid", {31'd0, Valid}, 32'd1);
            tick();
        end
        Stall = 1'b0;
        wait_drain("s2_drain", 10);

        // Scenario 5: reset while request to 0x20 is pending
        credits = 3;
        push(32'h0000_A014, 32'h18);
        push(32'h0000_A018, 32'h1C);
        push(32'h0000_A01C, 32'h20);
        wait_drain("s5_pre_drain", 30);
        mem_lat = 3;
        credits = 1;
        tick();
        tick();
        check("s5_pending_addr", IMemAddr, 32'h20);
        #1 Rst = 1'b1;
        #1;
        check("s5_rst_req", {31'd0, IMemReq}, 32'd0);
        check("s5_rst_addr", IMemAddr, 32'd0);
        check("s5_rst_instr", Instruction, 32'd0);
        check("s5_rst_pc4", PCPlus4, 32'd0);
        check("s5_rst_valid", {31'd0, Valid}, 32'd0);
        tick();
        tick();
        Rst = 1'b0;
        tick();
        check("s5_first_req", {31'd0, IMemReq}, 32'd1);
        check("s5_first_addr", IMemAddr, 32'd0);

        // Scenario 3: branch while request to 0x8 awaits its ack
        mem_lat = 1;
        credits = 2;
        push(32'h0000_A000, 32'h4);
        push(32'h0000_A004, 32'h8);
        wait_drain("s3_pre_drain", 30);
        check("s3_addr8", IMemAddr, 32'h8);
        mem_lat = 2;
        credits = 2;
        tick();
        BranchTaken = 1'b1;
        BranchTarget = 32'h40;
        tick();
        BranchTaken = 1'b0;
        check("s3_drop_req", {31'd0, IMemReq}, 32'd1);
        check("s3_drop_addr", IMemAddr, 32'h8);
        push(32'h0000_A040, 32'h44);
        wait_addr("s3_redirect_addr", 32'h40, 10);
        wait_drain("s3_drain", 20);

        // Scenario 4: branch coincident with ack under stall
        mem_lat = 1;
        credits = 3;
        Stall = 1'b1;
        push(32'h0000_A044, 32'h48);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (IMemAck && IMemAddr == 32'h48) begin
                hit = 1'b1;
                break;
            end
        end
        check("s4_ack_seen", {31'd0, hit}, 32'd1);
        BranchTaken = 1'b1;
        BranchTarget = 32'h100;
        tick();
        BranchTaken = 1'b0;
        check("s4_valid", {31'd0, Valid}, 32'd0);
        check("s4_addr", IMemAddr, 32'h100);
        Stall = 1'b0;
        push(32'h0000_A100, 32'h104);
        wait_drain("s4_drain", 20);

        // Scenario 6: address wrap at 0xFFFFFFFC
        BranchTaken = 1'b1;
        BranchTarget = 32'hFFFF_FFFC;
        tick();
        BranchTaken = 1'b0;
        credits = 3;
        push(32'hFFFF_FFFC, 32'h0);
        push(32'h0000_A000, 32'h4);
        wait_addr("s6_wrap_addr", 32'h0, 20);
        wait_drain("s6_drain", 20);

        repeat (5) tick();
        check("final_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Clk  input  1  rising-edge clock for all state.
REQ-002 Rst  input  1  reset: asynchronous, active-high; clock Clk.
REQ-003 Stall  input  1  decode stage cannot consume the current IF/ID output this cycle.
REQ-004 BranchTaken  input  1  single-cycle redirect request (branch & Zero from execute).
REQ-005 BranchTarget  input  32  redirect address; sampled only when BranchTaken=1.
REQ-006 IMemReq  output  1  instruction-memory request.
REQ-007 IMemAddr  output  32  word address of the outstanding request (FetchPC register).
REQ-008 IMemAck  input  1  single-cycle response strobe; the memory asserts it only while IMemReq=1.
REQ-009 IMemData  input  32  instruction word; valid when IMemAck=1.
REQ-010 Instruction  output  32  registered IF/ID instruction.
REQ-011 PCPlus4  output  32  registered (address of Instruction)+4.
REQ-012 Valid  output  1  Instruction/PCPlus4 hold a live instruction.

Function
REQ-013 The block SHALL implement the states IDLE, REQ, HOLD and DROP.
REQ-014 IMemReq SHALL be 1 exactly in REQ and DROP; IMemAddr SHALL stay stable from request assertion until the ack edge.
REQ-015 IDLE SHALL last one cycle after reset release with IMemReq=0, then go to REQ.
REQ-016 "Consume" SHALL mean a rising edge with Valid=1 and Stall=0; at that edge Valid SHALL clear unless a new word is loaded.
REQ-017 On an ack edge in REQ with no BranchTaken, the block SHALL set FetchPC to FetchPC+4 and route the word, with PCPlus4=old FetchPC+4, as follows:
- To the output register if Valid=0 or consume occurs; Valid=1; stay in REQ.
- Otherwise to the one-entry skid buffer (SkidValid=1); go to HOLD.
REQ-018 In HOLD, on consume, the skid contents SHALL move to the output register (Valid=1), SkidValid SHALL clear, and the state SHALL become REQ.
REQ-019 On BranchTaken=1, Valid and SkidValid SHALL clear at that edge regardless of Stall; BranchTaken SHALL take priority over Stall and ack. The next state SHALL be:
- From REQ with ack: FetchPC=BranchTarget, state REQ, data discarded.
- From REQ without ack: RedirectPC=BranchTarget, state DROP.
- From HOLD or IDLE: FetchPC=BranchTarget, state REQ.
- From DROP: RedirectPC=BranchTarget (latest wins), state DROP.
REQ-020 In DROP, on ack, the block SHALL discard the data, set FetchPC=RedirectPC, and go to REQ; it SHALL never emit discarded data.
REQ-021 Addresses SHALL use 32-bit modulo arithmetic; 0xFFFFFFFC+4 SHALL wrap to 0x00000000.
REQ-022 Fetch-to-output latency SHALL be zero cycles after the ack edge, so Valid=1 in the cycle following the ack.

Reset
REQ-023 Rst=1 SHALL immediately set state=IDLE, FetchPC=0, RedirectPC=0, SkidValid=0, Instruction=0, PCPlus4=0, Valid=0, IMemReq=0, and IMemAddr=0.
REQ-024 Reset during an outstanding request SHALL abandon it; the memory model SHALL drop its pending ack on Rst.

Verification
REQ-025 Scenario 1: reset release, memory acks each request 1 cycle later with data=addr|0xA000 -> Instruction 0xA000,0xA004,0xA008 with PCPlus4 4,8,0xC and no gaps beyond ack latency.
REQ-026 Scenario 2: Valid=1 and Stall=1 for 3 cycles while ack arrives -> state HOLD, IMemReq=0, and Instruction unchanged; on Stall=0 the skid word appears next cycle with no loss or duplication.
REQ-027 Scenario 3: BranchTaken with target 0x40 while a request to 0x8 awaits ack (ack 2 cycles later) -> DROP state, 0x8 data never emitted, next IMemAddr=0x40, next Instruction from 0x40 with PCPlus4=0x44.
REQ-028 Scenario 4: BranchTaken with target 0x100 coincident with ack and Stall=1 -> Valid=0 next cycle and the next request goes to 0x100.
REQ-029 Scenario 5: Rst asserted mid-request at FetchPC=0x20 -> all outputs 0 asynchronously; after release, the first request goes to 0x0.
REQ-030 Scenario 6: FetchPC=0xFFFFFFFC, ack -> PCPlus4=0x00000000 and the next IMemAddr=0x00000000.
